bist_ctrl: RTL

Top-level BIST sequencer for one SRAM macro. Runs a bank of `NUM_PATGENS` pattern generators one after another. The active generator's address, data, mask and strobes are muxed onto the SRAM port. Read data is compared against the generator's expected value after the macro's read latency. Results are a single done/fail outcome plus a capture of the first failing access.

---
 rtl/bist_ctrl_if.sv | 38 +++
 rtl/bist_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bist_ctrl_if.sv
// ---------------------------------------------------------------------------
// bist_ctrl_if
// SRAM port bundle between the BIST sequencer and one SRAM macro.
//
// Signals:
//   sram_addr   ADDR_WIDTH  access address
//   sram_din    DATA_WIDTH  write data
//   sram_wmask  MASK_WIDTH  write mask
//   sram_we     1           write strobe
//   sram_re     1           read strobe
//   sram_dout   DATA_WIDTH  read data, valid READ_LATENCY cycles after sram_re
//
// Modports:
//   master  the BIST sequencer (drives address, data, mask, strobes)
//   slave   the SRAM macro (drives read data)
// ---------------------------------------------------------------------------
interface bist_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_din;
  logic [MASK_WIDTH-1:0] sram_wmask;
  logic                  sram_we;
  logic                  sram_re;
  logic [DATA_WIDTH-1:0] sram_dout;

  modport master (
    output sram_addr, sram_din, sram_wmask, sram_we, sram_re,
    input  sram_dout
  );

  modport slave (
    input  sram_addr, sram_din, sram_wmask, sram_we, sram_re,
    output sram_dout
  );
endinterface : bist_ctrl_if

// File: rtl/bist_ctrl.sv
// ---------------------------------------------------------------------------
// bist_ctrl
// BIST sequencer for one SRAM macro. Runs NUM_PATGENS external pattern
// generators one after another, muxes the active generator onto the SRAM
// port, and compares read data against the generator's expected value after
// the macro's read latency. Reports done/fail plus a capture of the first
// failing access.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin a run (accepted in IDLE or DONE only)
//   busy, done      run in progress / run finished
//   fail            sticky miscompare flag for the current run
//   fail_addr/_data/_expected/_pg   capture of the first miscompare
//   fail_count      miscompare counter (only with BIST_CTRL_FAIL_COUNT_EN)
//   pg_rst, pg_en   per-generator reset and enable
//   pg_addr, pg_data, pg_expected, pg_wmask, pg_we, pg_re, pg_done
//                   generator outputs, generator i in slice i
//   sram            bist_ctrl_if master: SRAM address/data/mask/strobes
//
// Build option:
//   BIST_CTRL_FAIL_COUNT_EN  adds the saturating 16-bit fail_count output.
// ---------------------------------------------------------------------------
module bist_ctrl #(
  parameter  int ADDR_WIDTH   = 8,
  parameter  int DATA_WIDTH   = 32,
  parameter  int MASK_WIDTH   = 4,
  parameter  int NUM_PATGENS  = 2,
  parameter  int READ_LATENCY = 1,
  localparam int PG_W         = (NUM_PATGENS > 1) ? $clog2(NUM_PATGENS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              fail,
  output logic [ADDR_WIDTH-1:0]             fail_addr,
  output logic [DATA_WIDTH-1:0]             fail_data,
  output logic [DATA_WIDTH-1:0]             fail_expected,
  output logic [PG_W-1:0]                   fail_pg,
  output logic [NUM_PATGENS-1:0]            pg_rst,
  output logic [NUM_PATGENS-1:0]            pg_en,
  input  logic [NUM_PATGENS*ADDR_WIDTH-1:0] pg_addr,
  input  logic [NUM_PATGENS*DATA_WIDTH-1:0] pg_data,
  input  logic [NUM_PATGENS*DATA_WIDTH-1:0] pg_expected,
  input  logic [NUM_PATGENS*MASK_WIDTH-1:0] pg_wmask,
  input  logic [NUM_PATGENS-1:0]            pg_we,
  input  logic [NUM_PATGENS-1:0]            pg_re,
  input  logic [NUM_PATGENS-1:0]            pg_done,
`ifdef BIST_CTRL_FAIL_COUNT_EN
  output logic [15:0]                       fail_count,
`endif
  bist_ctrl_if.master                       sram
);

  localparam int        DRAIN_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam [PG_W-1:0] LAST_SEL = PG_W'(NUM_PATGENS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PG_RST,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] expected;
    logic [PG_W-1:0]       pg;
  } cmp_t;

  state_t                  state;
  logic [PG_W-1:0]         sel;
  logic [PG_W-1:0]         next_sel;
  logic [DRAIN_W-1:0]      drain_cnt;
  logic [NUM_PATGENS-1:0]  sel_onehot;
  logic                    start_ok;
  logic                    run;

  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [DATA_WIDTH-1:0]   cur_data;
  logic [DATA_WIDTH-1:0]   cur_expected;
  logic [MASK_WIDTH-1:0]   cur_wmask;
  logic                    cur_we;
  logic                    cur_re;
  logic                    cur_done;

  logic [READ_LATENCY-1:0] pipe_valid;
  cmp_t                    pipe_data [READ_LATENCY];
  logic                    miscompare;

  assign sel_onehot = NUM_PATGENS'(1) << sel;
  assign next_sel   = PG_W'(sel + 1'b1);
  assign start_ok   = start && (state == S_IDLE || state == S_DONE);
  assign run        = (state == S_RUN);

  // Active generator slice.
  assign cur_addr     = pg_addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
  assign cur_data     = pg_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
  assign cur_expected = pg_expected[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
  assign cur_wmask    = pg_wmask[int'(sel)*MASK_WIDTH +: MASK_WIDTH];
  assign cur_we       = pg_we[sel];
  assign cur_re       = pg_re[sel];
  assign cur_done     = pg_done[sel];

  // SRAM port mirrors the selected generator only while in RUN; a generator
  // that has raised done can no longer issue strobes.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    sram.sram_addr  = '0;
    sram.sram_din   = '0;
    sram.sram_wmask = '0;
    sram.sram_we    = 1'b0;
    sram.sram_re    = 1'b0;
    pg_en           = '0;
    if (run) begin
      sram.sram_addr  = cur_addr;
      sram.sram_din   = cur_data;
      sram.sram_wmask = cur_wmask;
      sram.sram_we    = cur_we & ~cur_done;
      sram.sram_re    = cur_re & ~cur_done;
      if (!cur_done) pg_en = sel_onehot;
    end
  end

  // Sequencer FSM with registered busy/done/pg_rst.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state     <= S_IDLE;
      sel       <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pg_rst    <= '1;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state  <= S_PG_RST;
            sel    <= '0;
            busy   <= 1'b1;
            done   <= 1'b0;
            pg_rst <= NUM_PATGENS'(1);
          end
        end
        S_PG_RST: begin
          pg_rst <= '0;
          state  <= S_RUN;
        end
        S_RUN: begin
          if (cur_done) begin
            state     <= S_DRAIN;
            drain_cnt <= DRAIN_W'(READ_LATENCY - 1);
          end
        end
        S_DRAIN: begin
          // Wait out the read latency so the generator's last read is
          // compared before the next generator starts or done rises.
          if (drain_cnt == '0) begin
            if (sel == LAST_SEL) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              sel    <= next_sel;
              state  <= S_PG_RST;
              pg_rst <= NUM_PATGENS'(1) << next_sel;
            end
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Compare pipeline: only the valid bits need a reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= sram.sram_re;
      for (int i = 1; i < READ_LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
    end
  end

  // NOTE: the payload stages are qualified by pipe_valid and are deliberately
  // not reset; resetting a data array only adds reset fan-out.
  always_ff @(posedge clk) begin
    pipe_data[0].addr     <= sram.sram_addr;
    pipe_data[0].expected <= cur_expected;
    pipe_data[0].pg       <= sel;
    for (int i = 1; i < READ_LATENCY; i++) pipe_data[i] <= pipe_data[i-1];
  end

  assign miscompare = pipe_valid[READ_LATENCY-1] &&
                      (sram.sram_dout != pipe_data[READ_LATENCY-1].expected);

  // Sticky fail flag and first-failure capture; an accepted start clears them.
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      fail          <= 1'b0;
      fail_addr     <= '0;
      fail_data     <= '0;
      fail_expected <= '0;
      fail_pg       <= '0;
    end else if (miscompare && !fail) begin
      fail          <= 1'b1;
      fail_addr     <= pipe_data[READ_LATENCY-1].addr;
      fail_data     <= sram.sram_dout;
      fail_expected <= pipe_data[READ_LATENCY-1].expected;
      fail_pg       <= pipe_data[READ_LATENCY-1].pg;
    end
  end

`ifdef BIST_CTRL_FAIL_COUNT_EN
  // Saturating count of every miscompare in the current run.
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      fail_count <= '0;
    end else if (miscompare && fail_count != 16'hFFFF) begin
      fail_count <= fail_count + 16'd1;
    end
  end
`endif

endmodule : bist_ctrl
